sram_port0_arbiter: RTL and testbench

Arbiter and sequencer for the read/write port (port 0) of the 32x256 sky130 SRAM macro. It shares the port between two external requesters using round-robin, and runs a lowest-priority internal sweep engine that streams a contiguous address range out of the macro. It returns read data to whichever source issued the read. It sits directly in front of the macro; port 1 of the macro is not touched.

---
 rtl/sram_port0_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_sram_port0_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port0_arbiter.sv
// Port-0 arbiter for the 32x256 sky130 SRAM: round-robin between two requesters,
// a lowest-priority sweep engine, and a 1-deep tagged read-response return path.
`timescale 1ns/1ps
module sram_port0_arbiter #(
    parameter int NUM_WMASKS = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    r0_valid,
    output logic                    r0_ready,
    input  logic                    r0_we,
    input  logic [NUM_WMASKS-1:0]   r0_wmask,
    input  logic [ADDR_WIDTH-1:0]   r0_addr,
    input  logic [DATA_WIDTH-1:0]   r0_wdata,
    output logic                    r0_rvalid,
    output logic [DATA_WIDTH-1:0]   r0_rdata,

    input  logic                    r1_valid,
    output logic                    r1_ready,
    input  logic                    r1_we,
    input  logic [NUM_WMASKS-1:0]   r1_wmask,
    input  logic [ADDR_WIDTH-1:0]   r1_addr,
    input  logic [DATA_WIDTH-1:0]   r1_wdata,
    output logic                    r1_rvalid,
    output logic [DATA_WIDTH-1:0]   r1_rdata,

    input  logic                    sweep_start,
    input  logic [ADDR_WIDTH-1:0]   sweep_base,
    input  logic [ADDR_WIDTH:0]     sweep_len,
    input  logic                    sweep_abort,
    output logic                    sweep_busy,
    output logic                    sweep_valid,
    output logic [ADDR_WIDTH-1:0]   sweep_addr,
    output logic [DATA_WIDTH-1:0]   sweep_data,
    output logic                    sweep_done,

    output logic                    sram_csb0,
    output logic                    sram_web0,
    output logic [NUM_WMASKS-1:0]   sram_wmask0,
    output logic [ADDR_WIDTH-1:0]   sram_addr0,
    output logic [DATA_WIDTH-1:0]   sram_din0,
    input  logic [DATA_WIDTH-1:0]   sram_dout0
);

    typedef enum logic [1:0] {
        SW_IDLE  = 2'd0,
        SW_RUN   = 2'd1,
        SW_DRAIN = 2'd2
    } sweepState_e;

    typedef enum logic [1:0] {
        TAG_NONE  = 2'd0,
        TAG_R0    = 2'd1,
        TAG_R1    = 2'd2,
        TAG_SWEEP = 2'd3
    } rspTag_e;

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = 1;
    localparam logic [ADDR_WIDTH:0]   LEFT_ONE = 1;

    sweepState_e            state_q;
    logic [ADDR_WIDTH-1:0]  swPtr_q;
    logic [ADDR_WIDTH:0]    swLeft_q;

    logic                   lastR1_q, lastR1_d;
    rspTag_e                tag_q, tag_d;
    logic [ADDR_WIDTH-1:0]  rspAddr_q, rspAddr_d;

    logic                   gntR0, gntR1, gntSw;

    // Grant gated by rst_n so ready and the macro pins drop as soon as reset asserts.
    // An abort also blocks the sweep grant, so an aborted sweep never spends a macro access.
    always_comb begin
        gntR0 = 1'b0;
        gntR1 = 1'b0;
        gntSw = 1'b0;
        if (rst_n) begin
            if (r0_valid && r1_valid) begin
                if (lastR1_q) gntR0 = 1'b1;
                else          gntR1 = 1'b1;
            end else if (r0_valid) begin
                gntR0 = 1'b1;
            end else if (r1_valid) begin
                gntR1 = 1'b1;
            end else if (state_q == SW_RUN && !sweep_abort) begin
                gntSw = 1'b1;
            end
        end
    end

    assign r0_ready = gntR0;
    assign r1_ready = gntR1;

    always_comb begin
        sram_csb0   = 1'b1;
        sram_web0   = 1'b1;
        sram_wmask0 = '0;
        sram_addr0  = '0;
        sram_din0   = '0;
        if (gntR0) begin
            sram_csb0   = 1'b0;
            sram_web0   = ~r0_we;
            sram_wmask0 = r0_wmask;
            sram_addr0  = r0_addr;
            sram_din0   = r0_wdata;
        end else if (gntR1) begin
            sram_csb0   = 1'b0;
            sram_web0   = ~r1_we;
            sram_wmask0 = r1_wmask;
            sram_addr0  = r1_addr;
            sram_din0   = r1_wdata;
        end else if (gntSw) begin
            sram_csb0   = 1'b0;
            sram_addr0  = swPtr_q;
        end
    end

    // Writes leave no tag behind; only reads expect data from the macro next cycle.
    always_comb begin
        lastR1_d  = lastR1_q;
        tag_d     = TAG_NONE;
        rspAddr_d = rspAddr_q;
        if (gntR0) begin
            lastR1_d = 1'b0;
            if (!r0_we) tag_d = TAG_R0;
        end else if (gntR1) begin
            lastR1_d = 1'b1;
            if (!r1_we) tag_d = TAG_R1;
        end else if (gntSw) begin
            tag_d     = TAG_SWEEP;
            rspAddr_d = swPtr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lastR1_q  <= 1'b1;
            tag_q     <= TAG_NONE;
            rspAddr_q <= '0;
        end else begin
            lastR1_q  <= lastR1_d;
            tag_q     <= tag_d;
            rspAddr_q <= rspAddr_d;
        end
    end

    // Sweep sequencer: DRAIN holds for exactly the cycle the final word returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= SW_IDLE;
            swPtr_q  <= '0;
            swLeft_q <= '0;
        end else begin
            case (state_q)
                SW_IDLE: begin
                    if (sweep_start && sweep_len != '0) begin
                        state_q  <= SW_RUN;
                        swPtr_q  <= sweep_base;
                        swLeft_q <= sweep_len;
                    end
                end
                SW_RUN: begin
                    if (sweep_abort) begin
                        state_q <= SW_IDLE;
                    end else if (gntSw) begin
                        swPtr_q  <= swPtr_q + PTR_ONE;
                        swLeft_q <= swLeft_q - LEFT_ONE;
                        if (swLeft_q == LEFT_ONE) state_q <= SW_DRAIN;
                    end
                end
                SW_DRAIN: state_q <= SW_IDLE;
                default:  state_q <= SW_IDLE;
            endcase
        end
    end

    assign sweep_busy  = (state_q != SW_IDLE);

    assign r0_rvalid   = (tag_q == TAG_R0);
    assign r1_rvalid   = (tag_q == TAG_R1);
    assign r0_rdata    = sram_dout0;
    assign r1_rdata    = sram_dout0;

    assign sweep_valid = (tag_q == TAG_SWEEP) && !sweep_abort;
    assign sweep_done  = sweep_valid && (state_q == SW_DRAIN);
    assign sweep_addr  = rspAddr_q;
    assign sweep_data  = sram_dout0;

endmodule

// File: tb/tb_sram_port0_arbiter.sv
// Bench for sram_port0_arbiter: behavioural SRAM macro, queue-based reference
// model checked every cycle, directed scenarios with literal expectations, random traffic.
`timescale 1ns/1ps
module tb_sram_port0_arbiter;

    logic        clk;
    logic        rst_n;
    logic        r0_valid, r0_ready, r0_we, r0_rvalid;
    logic [3:0]  r0_wmask;
    logic [7:0]  r0_addr;
    logic [31:0] r0_wdata, r0_rdata;
    logic        r1_valid, r1_ready, r1_we, r1_rvalid;
    logic [3:0]  r1_wmask;
    logic [7:0]  r1_addr;
    logic [31:0] r1_wdata, r1_rdata;
    logic        sweep_start, sweep_abort, sweep_busy, sweep_valid, sweep_done;
    logic [7:0]  sweep_base, sweep_addr;
    logic [8:0]  sweep_len;
    logic [31:0] sweep_data;
    logic        sram_csb0, sram_web0;
    logic [3:0]  sram_wmask0;
    logic [7:0]  sram_addr0;
    logic [31:0] sram_din0, sram_dout0;

    int checks = 0;
    int errors = 0;

    sram_port0_arbiter #(.NUM_WMASKS(4), .DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we), .r0_wmask(r0_wmask),
        .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we), .r1_wmask(r1_wmask),
        .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .sweep_start(sweep_start), .sweep_base(sweep_base), .sweep_len(sweep_len),
        .sweep_abort(sweep_abort), .sweep_busy(sweep_busy), .sweep_valid(sweep_valid),
        .sweep_addr(sweep_addr), .sweep_data(sweep_data), .sweep_done(sweep_done),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
        .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] initWord(input int idx);
        return (32'(idx) * 32'h9E3779B9) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] mergeWord(input logic [31:0] old, input logic [31:0] nw,
                                              input logic [3:0] mask);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++)
            if (mask[b]) res[b*8 +: 8] = nw[b*8 +: 8];
        return res;
    endfunction

    // Behavioural sky130 macro port 0: synchronous, read data appears after the edge.
    logic [31:0] sramMem [256];
    initial begin
        for (int i = 0; i < 256; i++) sramMem[i] = initWord(i);
        sram_dout0 = '0;
        forever begin
            @(posedge clk);
            if (!sram_csb0) begin
                if (!sram_web0) sramMem[sram_addr0] = mergeWord(sramMem[sram_addr0], sram_din0, sram_wmask0);
                else            sram_dout0 <= sramMem[sram_addr0];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_r0_ready"},    64'(r0_ready),    64'd0);
        checkOutput({tag, "_r1_ready"},    64'(r1_ready),    64'd0);
        checkOutput({tag, "_r0_rvalid"},   64'(r0_rvalid),   64'd0);
        checkOutput({tag, "_r1_rvalid"},   64'(r1_rvalid),   64'd0);
        checkOutput({tag, "_sweep_valid"}, 64'(sweep_valid), 64'd0);
        checkOutput({tag, "_sweep_done"},  64'(sweep_done),  64'd0);
        checkOutput({tag, "_sweep_busy"},  64'(sweep_busy),  64'd0);
        checkOutput({tag, "_csb0"},        64'(sram_csb0),   64'd1);
        checkOutput({tag, "_web0"},        64'(sram_web0),   64'd1);
        checkOutput({tag, "_wmask0"},      64'(sram_wmask0), 64'd0);
        checkOutput({tag, "_addr0"},       64'(sram_addr0),  64'd0);
        checkOutput({tag, "_din0"},        64'(sram_din0),   64'd0);
    endtask

    // Reference model: sweep = queue of addresses still to issue, plus one pending response.
    logic [31:0] shadow [256];
    logic [7:0]  sweepQ [$];
    bit          rspValid;
    int          rspSrc;
    logic [7:0]  rspAddr;
    logic [31:0] rspData;
    bit          lastR1;

    int          cycleNo = 0;
    int          busyTotal = 0;
    int          doneTotal = 0;
    int          swValidTotal = 0;
    logic [7:0]  swAddrLog [$];
    int          swCycleLog [$];
    logic [7:0]  doneAddrLog [$];

    initial begin
        int          g;
        bit          ab, busyM, swv;
        bit          cWe;
        logic [3:0]  cMask;
        logic [7:0]  cAddr;
        logic [31:0] cData;
        bit          eWeb;
        logic [3:0]  eMask;
        logic [7:0]  eAddr;
        logic [31:0] eDin;
        for (int i = 0; i < 256; i++) shadow[i] = initWord(i);
        rspValid = 0;
        lastR1 = 1;
        forever begin
            @(negedge clk);
            cycleNo++;
            if (!rst_n) begin
                checkIdle("reset");
                sweepQ.delete();
                rspValid = 0;
                lastR1 = 1;
            end else begin
                g = -1;
                if (r0_valid && r1_valid)               g = lastR1 ? 0 : 1;
                else if (r0_valid)                      g = 0;
                else if (r1_valid)                      g = 1;
                else if (sweepQ.size() > 0 && !sweep_abort) g = 2;
                ab    = sweep_abort;
                busyM = (sweepQ.size() > 0) || (rspValid && rspSrc == 2);
                swv   = rspValid && rspSrc == 2 && !ab;

                cWe = (g == 1) ? r1_we : r0_we;
                cMask = (g == 1) ? r1_wmask : r0_wmask;
                cAddr = (g == 1) ? r1_addr : r0_addr;
                cData = (g == 1) ? r1_wdata : r0_wdata;
                eWeb = 1; eMask = '0; eAddr = '0; eDin = '0;
                if (g == 0 || g == 1) begin
                    eWeb = !cWe; eMask = cMask; eAddr = cAddr; eDin = cData;
                end else if (g == 2) begin
                    eAddr = sweepQ[0];
                end

                checkOutput("r0_ready",    64'(r0_ready),    64'(g == 0));
                checkOutput("r1_ready",    64'(r1_ready),    64'(g == 1));
                checkOutput("sram_csb0",   64'(sram_csb0),   64'(g < 0));
                checkOutput("sram_web0",   64'(sram_web0),   64'(eWeb));
                checkOutput("sram_wmask0", 64'(sram_wmask0), 64'(eMask));
                checkOutput("sram_addr0",  64'(sram_addr0),  64'(eAddr));
                checkOutput("sram_din0",   64'(sram_din0),   64'(eDin));
                checkOutput("r0_rvalid",   64'(r0_rvalid),   64'(rspValid && rspSrc == 0));
                checkOutput("r1_rvalid",   64'(r1_rvalid),   64'(rspValid && rspSrc == 1));
                if (rspValid && rspSrc == 0) checkOutput("r0_rdata", 64'(r0_rdata), 64'(rspData));
                if (rspValid && rspSrc == 1) checkOutput("r1_rdata", 64'(r1_rdata), 64'(rspData));
                checkOutput("sweep_valid", 64'(sweep_valid), 64'(swv));
                checkOutput("sweep_done",  64'(sweep_done),  64'(swv && sweepQ.size() == 0));
                checkOutput("sweep_busy",  64'(sweep_busy),  64'(busyM));
                if (swv) begin
                    checkOutput("sweep_addr", 64'(sweep_addr), 64'(rspAddr));
                    checkOutput("sweep_data", 64'(sweep_data), 64'(rspData));
                end

                if (sweep_busy) busyTotal++;
                if (sweep_valid) begin
                    swValidTotal++;
                    swAddrLog.push_back(sweep_addr);
                    swCycleLog.push_back(cycleNo);
                end
                if (sweep_done) begin
                    doneTotal++;
                    doneAddrLog.push_back(sweep_addr);
                end

                rspValid = 0;
                if (g == 0 || g == 1) begin
                    lastR1 = (g == 1);
                    if (cWe) begin
                        shadow[cAddr] = mergeWord(shadow[cAddr], cData, cMask);
                    end else begin
                        rspValid = 1; rspSrc = g; rspAddr = cAddr; rspData = shadow[cAddr];
                    end
                end else if (g == 2) begin
                    rspAddr  = sweepQ.pop_front();
                    rspValid = 1; rspSrc = 2; rspData = shadow[rspAddr];
                end
                if (!busyM) begin
                    if (sweep_start && sweep_len != 0)
                        for (int i = 0; i < int'(sweep_len); i++) sweepQ.push_back(8'(int'(sweep_base) + i));
                end else if (ab) begin
                    sweepQ.delete();
                end
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clearInputs();
        r0_valid = 0; r0_we = 0; r0_wmask = '0; r0_addr = '0; r0_wdata = '0;
        r1_valid = 0; r1_we = 0; r1_wmask = '0; r1_addr = '0; r1_wdata = '0;
        sweep_start = 0; sweep_base = '0; sweep_len = '0; sweep_abort = 0;
    endtask

    task automatic applyStimulus(input int src, input bit we, input logic [3:0] mask,
                                 input logic [7:0] addr, input logic [31:0] data);
        if (src == 0) begin
            r0_valid = 1; r0_we = we; r0_wmask = mask; r0_addr = addr; r0_wdata = data;
        end else begin
            r1_valid = 1; r1_we = we; r1_wmask = mask; r1_addr = addr; r1_wdata = data;
        end
    endtask

    task automatic startSweep(input logic [7:0] base, input logic [8:0] len);
        sweep_start = 1; sweep_base = base; sweep_len = len;
        step(1);
        clearInputs();
    endtask

    initial begin
        int b0, d0, v0, l0;
        logic [7:0] expFE [4];
        expFE[0] = 8'hFE; expFE[1] = 8'hFF; expFE[2] = 8'h00; expFE[3] = 8'h01;

        clearInputs();
        rst_n = 0;
        step(3);
        checkIdle("por");
        rst_n = 1;

        // Tie right after reset: r0 wins first, then strict alternation.
        for (int i = 0; i < 6; i++) begin
            clearInputs();
            applyStimulus(0, 0, 4'h0, 8'h30, 32'h0);
            applyStimulus(1, 0, 4'h0, 8'h31, 32'h0);
            @(negedge clk);
            checkOutput("tie_r0_ready", 64'(r0_ready), 64'((i % 2) == 0));
            checkOutput("tie_r1_ready", 64'(r1_ready), 64'((i % 2) == 1));
            step(1);
        end
        clearInputs();
        step(2);

        applyStimulus(0, 1, 4'hF, 8'h10, 32'hDEADBEEF);
        step(1);
        clearInputs();
        applyStimulus(0, 0, 4'h0, 8'h10, 32'h0);
        step(1);
        clearInputs();
        @(negedge clk);
        checkOutput("wr_rd_rvalid", 64'(r0_rvalid), 64'd1);
        checkOutput("wr_rd_rdata",  64'(r0_rdata),  64'h00000000DEADBEEF);
        checkOutput("wr_rd_r1idle", 64'(r1_rvalid), 64'd0);
        step(1);

        applyStimulus(1, 1, 4'hF, 8'h20, 32'h11223344);
        step(1);
        clearInputs();
        applyStimulus(1, 1, 4'h2, 8'h20, 32'h0000AB00);
        step(1);
        clearInputs();
        applyStimulus(1, 0, 4'h0, 8'h20, 32'h0);
        step(1);
        clearInputs();
        @(negedge clk);
        checkOutput("partial_rvalid", 64'(r1_rvalid), 64'd1);
        checkOutput("partial_rdata",  64'(r1_rdata),  64'h000000001122AB44);
        step(2);

        b0 = busyTotal; d0 = doneTotal; l0 = swAddrLog.size();
        startSweep(8'hFE, 9'd4);
        step(10);
        checkOutput("fe_busy",  64'(busyTotal - b0), 64'd5);
        checkOutput("fe_done",  64'(doneTotal - d0), 64'd1);
        checkOutput("fe_count", 64'(swAddrLog.size() - l0), 64'd4);
        if (swAddrLog.size() - l0 == 4) begin
            for (int i = 0; i < 4; i++) checkOutput("fe_addr", 64'(swAddrLog[l0 + i]), 64'(expFE[i]));
            checkOutput("fe_span", 64'(swCycleLog[l0 + 3] - swCycleLog[l0] + 1), 64'd4);
        end
        checkOutput("fe_done_addr", 64'(doneAddrLog[doneAddrLog.size() - 1]), 64'h01);

        d0 = doneTotal; l0 = swAddrLog.size();
        startSweep(8'h40, 9'd8);
        step(2);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 4'h0, 8'(8'h05 + i), 32'h0);
            step(1);
        end
        clearInputs();
        step(15);
        checkOutput("pause_done",  64'(doneTotal - d0), 64'd1);
        checkOutput("pause_count", 64'(swAddrLog.size() - l0), 64'd8);
        if (swAddrLog.size() - l0 == 8) begin
            for (int i = 0; i < 8; i++) checkOutput("pause_addr", 64'(swAddrLog[l0 + i]), 64'(8'h40 + i));
            checkOutput("pause_span", 64'(swCycleLog[l0 + 7] - swCycleLog[l0] + 1), 64'd11);
        end

        b0 = busyTotal; d0 = doneTotal; l0 = swAddrLog.size();
        startSweep(8'h00, 9'd256);
        step(270);
        checkOutput("full_busy",  64'(busyTotal - b0), 64'd257);
        checkOutput("full_done",  64'(doneTotal - d0), 64'd1);
        checkOutput("full_count", 64'(swAddrLog.size() - l0), 64'd256);

        startSweep(8'h80, 9'd20);
        step(5);
        sweep_abort = 1;
        step(1);
        clearInputs();
        v0 = swValidTotal; d0 = doneTotal;
        step(10);
        checkOutput("abort_valid", 64'(swValidTotal - v0), 64'd0);
        checkOutput("abort_done",  64'(doneTotal - d0),    64'd0);
        checkOutput("abort_busy",  64'(sweep_busy),        64'd0);

        startSweep(8'hC0, 9'd30);
        step(4);
        applyStimulus(0, 0, 4'h0, 8'h05, 32'h0);
        #2;
        rst_n = 0;
        #1;
        checkIdle("async");
        step(2);
        clearInputs();
        rst_n = 1;
        v0 = swValidTotal;
        step(10);
        checkOutput("post_reset_valid", 64'(swValidTotal - v0), 64'd0);
        checkOutput("post_reset_busy",  64'(sweep_busy),        64'd0);

        for (int c = 0; c < 3000; c++) begin
            r0_valid = ($urandom_range(0, 99) < 30);
            r0_we    = 1'($urandom_range(0, 1));
            r0_wmask = 4'($urandom_range(0, 15));
            r0_addr  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 31)) : 8'($urandom);
            r0_wdata = $urandom;
            r1_valid = ($urandom_range(0, 99) < 30);
            r1_we    = 1'($urandom_range(0, 1));
            r1_wmask = 4'($urandom_range(0, 15));
            r1_addr  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 31)) : 8'($urandom);
            r1_wdata = $urandom;
            sweep_start = ($urandom_range(0, 29) == 0);
            sweep_base  = 8'($urandom);
            sweep_len   = ($urandom_range(0, 9) == 0) ? 9'd0 : 9'($urandom_range(1, 24));
            sweep_abort = ($urandom_range(0, 79) == 0);
            step(1);
        end
        clearInputs();
        step(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
